sev_seg_scan_ctrl: RTL and testbench

SEV_SEG_SCAN_CTRL -- requirements
Module: sev_seg_scan_ctrl

---
 rtl/sev_seg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronised loads, PWM dimming and registered outputs.
// Defining SEV_SEG_LZ_BLANK_EN enables leading-zero blanking; the default build shows every nibble.
module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [3:0]              brightness_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_tick_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pending_flag;
  logic [4*NUM_DIGITS-1:0] disp_digits;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    post_reset;
  logic [25:0]             cnt_x16;
  logic [25:0]             lit_limit;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic [NUM_DIGITS-1:0]   an_act;
  logic                    blank;
  logic                    show;
  logic [6:0]              seg_act;
  logic                    dp_act;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign slot_end = (cnt == CNT_MAX);
  assign wrap     = slot_end && (idx == IDX_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) frame_tick_o <= 1'b0;
    else       frame_tick_o <= wrap;
  end

  // The transfer is written first so a coinciding load still leaves pending_flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_digits  <= '0;
      pend_dp      <= '0;
      pending_flag <= 1'b0;
      disp_digits  <= '0;
      disp_dp      <= '0;
    end else begin
      if (wrap && pending_flag) begin
        disp_digits  <= pend_digits;
        disp_dp      <= pend_dp;
        pending_flag <= 1'b0;
      end
      if (load_i) begin
        pend_digits  <= digits_i;
        pend_dp      <= dp_i;
        pending_flag <= 1'b1;
      end
    end
  end

  assign cnt_x16   = 26'(cnt) << 4;
  assign lit_limit = (26'(brightness_i) + 26'd1) * 26'(REFRESH_DIV);
  assign lit       = (cnt_x16 < lit_limit);

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    an_act  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = disp_digits[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_en    = digit_en_i[k];
        an_act[k] = digit_en_i[k];
      end
    end
  end

`ifdef SEV_SEG_LZ_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Digit 0 is never blanked, so msd stays 0 for an all-zero display value.
  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (disp_digits[4*k +: 4] != 4'h0) msd = IDX_W'(k);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  assign show    = cur_en && lit && !blank;
  assign seg_act = show ? hex_to_seg(cur_nib) : 7'h00;
  assign dp_act  = show && cur_dp;

  always_ff @(posedge clk) begin
    post_reset <= reset;
  end

  // Outputs also stay dark on the first cycle after reset releases.
  always_ff @(posedge clk) begin
    if (reset || post_reset) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_OFF;
      dp_o  <= SEG_INV;
    end else begin
      an_o  <= an_act ^ AN_OFF;
      seg_o <= seg_act ^ SEG_OFF;
      dp_o  <= dp_act ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl at NUM_DIGITS=8, REFRESH_DIV=16, active-low anodes and segments.
// Every task starts and ends on the negedge where frame_tick_o is high, so slot timing is known.
module tb_sev_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] digits_i;
  logic [7:0]  dp_i;
  logic [7:0]  digit_en_i;
  logic [3:0]  brightness_i;
  logic        load_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic        frame_tick_o;

  int checks   = 0;
  int failures = 0;

  // Active-low segment codes for 0x12345678, indexed by digit position.
  logic [6:0] scan_seg [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

  sev_seg_scan_ctrl #(
    .NUM_DIGITS(8),
    .REFRESH_DIV(16),
    .AN_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digits_i(digits_i),
    .dp_i(dp_i),
    .digit_en_i(digit_en_i),
    .brightness_i(brightness_i),
    .load_i(load_i),
    .seg_o(seg_o),
    .dp_o(dp_o),
    .an_o(an_o),
    .frame_tick_o(frame_tick_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1; load_i = 1'b0; digits_i = '0; dp_i = '0;
    digit_en_i = 8'hFF; brightness_i = 4'd15;
    repeat (3) @(negedge clk);
    checks++;
    if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_tick_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: an=%h seg=%h dp=%b tick=%b, want an=ff seg=7f dp=1 tick=0",
               an_o, seg_o, dp_o, frame_tick_o);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_tick_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_after: an=%h seg=%h dp=%b tick=%b, want an=ff seg=7f dp=1 tick=0",
               an_o, seg_o, dp_o, frame_tick_o);
    end
  endtask

  task automatic test_scan;
    logic [7:0] ea;
    logic       found;
    int         slot;
    digits_i = 32'h12345678; dp_i = 8'h01; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (frame_tick_o === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL first_tick: tick=%b after 300 cycles, want 1", frame_tick_o);
    end
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      slot = (j - 1) / 16;
      ea = ~(8'h01 << slot);
      checks++;
      if (an_o !== ea || seg_o !== scan_seg[slot] || dp_o !== (slot != 0) ||
          frame_tick_o !== (j == 128)) begin
        failures++;
        $display("[TB] FAIL scan j=%0d: an=%h seg=%h dp=%b tick=%b, want an=%h seg=%h dp=%b tick=%b",
                 j, an_o, seg_o, dp_o, frame_tick_o, ea, scan_seg[slot], slot != 0, j == 128);
      end
    end
  endtask

  task automatic test_frame_sync;
    int slot;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      slot = (j - 1) / 16;
      if (j % 16 == 8) begin
        checks++;
        if (seg_o !== scan_seg[slot]) begin
          failures++;
          $display("[TB] FAIL hold_old slot=%0d: seg=%h, want %h", slot, seg_o, scan_seg[slot]);
        end
      end
      if (j == 53) begin
        digits_i = 32'hAAAAAAAA; dp_i = 8'h00; load_i = 1'b1;
      end else begin
        load_i = 1'b0;
      end
    end
    checks++;
    if (frame_tick_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sync_tick: tick=%b, want 1", frame_tick_o);
    end
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      slot = (j - 1) / 16;
      if (j % 16 == 8) begin
        checks++;
        if (seg_o !== 7'h08 || an_o !== ~(8'h01 << slot) || dp_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL new_A slot=%0d: seg=%h an=%h dp=%b, want seg=08 an=%h dp=1",
                   slot, seg_o, an_o, dp_o, ~(8'h01 << slot));
        end
      end
    end
  endtask

  task automatic test_brightness;
    int         cnt;
    int         slot;
    int         lit_count;
    logic [6:0] es;
    brightness_i = 4'd3;
    lit_count = 0;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      cnt  = (j - 1) % 16;
      slot = (j - 1) / 16;
      es = (cnt < 4) ? 7'h08 : 7'h7F;
      if (seg_o === 7'h08) lit_count++;
      checks++;
      if (seg_o !== es || an_o !== ~(8'h01 << slot)) begin
        failures++;
        $display("[TB] FAIL pwm j=%0d: seg=%h an=%h, want seg=%h an=%h",
                 j, seg_o, an_o, es, ~(8'h01 << slot));
      end
      if (cnt == 15) begin
        checks++;
        if (lit_count != 4) begin
          failures++;
          $display("[TB] FAIL pwm_count slot=%0d: lit=%0d, want 4", slot, lit_count);
        end
        lit_count = 0;
      end
    end
    brightness_i = 4'd15;
  endtask

  task automatic test_digit_enable;
    int         slot;
    logic [7:0] ea;
    logic [6:0] es;
    digit_en_i = 8'h0F;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      slot = (j - 1) / 16;
      ea = (slot < 4) ? ~(8'h01 << slot) : 8'hFF;
      es = (slot < 4) ? 7'h08 : 7'h7F;
      checks++;
      if (an_o !== ea || seg_o !== es || dp_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL enable j=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 j, an_o, seg_o, dp_o, ea, es);
      end
    end
    digit_en_i = 8'hFF;
  endtask

  task automatic test_blank;
    int         slot;
    logic [6:0] es;
    digits_i = 32'h00000A05; dp_i = 8'h00; load_i = 1'b1;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      load_i = 1'b0;
    end
    checks++;
    if (frame_tick_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL blank_tick: tick=%b, want 1", frame_tick_o);
    end
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      slot = (j - 1) / 16;
      case (slot)
        0:       es = 7'h12;
        1:       es = 7'h40;
        2:       es = 7'h08;
`ifdef SEV_SEG_LZ_BLANK_EN
        default: es = 7'h7F;
`else
        default: es = 7'h40;
`endif
      endcase
      if (j % 16 == 8) begin
        checks++;
        if (seg_o !== es || an_o !== ~(8'h01 << slot)) begin
          failures++;
          $display("[TB] FAIL blank slot=%0d: seg=%h an=%h, want seg=%h an=%h",
                   slot, seg_o, an_o, es, ~(8'h01 << slot));
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int         slot;
    logic [6:0] es;
    digits_i = 32'h11111111; dp_i = 8'hFF; load_i = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      load_i = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_tick_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: an=%h seg=%h dp=%b tick=%b, want an=ff seg=7f dp=1 tick=0",
               an_o, seg_o, dp_o, frame_tick_o);
    end
    @(negedge clk);
    checks++;
    if (an_o !== 8'hFF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_tick_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_after: an=%h seg=%h dp=%b tick=%b, want an=ff seg=7f dp=1 tick=0",
               an_o, seg_o, dp_o, frame_tick_o);
    end
    for (int k = 2; k <= 128; k++) begin
      @(negedge clk);
      checks++;
      if (frame_tick_o !== (k == 128)) begin
        failures++;
        $display("[TB] FAIL restart_tick k=%0d: tick=%b, want %b", k, frame_tick_o, k == 128);
      end
    end
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      slot = (j - 1) / 16;
`ifdef SEV_SEG_LZ_BLANK_EN
      es = (slot == 0) ? 7'h40 : 7'h7F;
`else
      es = 7'h40;
`endif
      if (j % 16 == 8) begin
        checks++;
        if (seg_o !== es || dp_o !== 1'b1 || an_o !== ~(8'h01 << slot)) begin
          failures++;
          $display("[TB] FAIL discard slot=%0d: seg=%h dp=%b an=%h, want seg=%h dp=1 an=%h",
                   slot, seg_o, dp_o, an_o, es, ~(8'h01 << slot));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_sync();
    test_brightness();
    test_digit_enable();
    test_blank();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
